// File: rtl/odom_frame_tx_if.sv
// Handshake bundle between the odometry frame transmitter and its environment
// (frame requester plus byte serializer).
`timescale 1ns/1ps
interface odom_frame_tx_if;
    logic        frame_start;
    logic [15:0] cnt_left;
    logic [15:0] cnt_right;
    logic        transm_rdy;
    logic [7:0]  data;
    logic        data_rdy;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    modport master (
        output frame_start, cnt_left, cnt_right, transm_rdy,
        input  data, data_rdy, busy, frame_done, overrun
    );

    modport slave (
        input  frame_start, cnt_left, cnt_right, transm_rdy,
        output data, data_rdy, busy, frame_done, overrun
    );
endinterface

// File: rtl/odom_frame_tx.sv
// Odometry frame transmitter: snapshots two encoder counts and sends an 8-byte
// frame (sync, sync, seq, counts, checksum) through a byte-serializer handshake.
`timescale 1ns/1ps
module odom_frame_tx #(
    parameter logic [7:0] SYNC0 = 8'hAA,
    parameter logic [7:0] SYNC1 = 8'h55
) (
    input  logic           clk,
    input  logic           rst_n,
    odom_frame_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [2:0]  r_idx;
    logic [2:0]  w_idxNext;
    logic [7:0]  r_seq;
    logic [7:0]  w_seqNext;
    logic [7:0]  r_frameSeq;
    logic [7:0]  w_frameSeqNext;
    logic [15:0] r_left;
    logic [15:0] w_leftNext;
    logic [15:0] r_right;
    logic [15:0] w_rightNext;
    logic [7:0]  r_data;
    logic [7:0]  w_dataNext;
    logic        r_dataRdy;
    logic        w_dataRdyNext;
    logic        r_busy;
    logic        w_busyNext;
    logic        r_frameDone;
    logic        w_frameDoneNext;
    logic        r_overrun;
    logic        w_overrunNext;
    logic [7:0]  w_chk;
    logic [7:0]  w_byte;

    // Checksum comes straight from the captured registers, so it is ready long before byte 7 is issued.
    assign w_chk = r_frameSeq + r_left[15:8] + r_left[7:0] + r_right[15:8] + r_right[7:0];

    always_comb begin
        w_byte = SYNC0;
        case (r_idx)
            3'd0: w_byte = SYNC0;
            3'd1: w_byte = SYNC1;
            3'd2: w_byte = r_frameSeq;
            3'd3: w_byte = r_left[15:8];
            3'd4: w_byte = r_left[7:0];
            3'd5: w_byte = r_right[15:8];
            3'd6: w_byte = r_right[7:0];
            3'd7: w_byte = w_chk;
            default: w_byte = SYNC0;
        endcase
    end

    // Outputs are registered; frame_done is raised on entry to NEXT so busy is still high alongside it.
    always_comb begin
        w_stateNext     = r_state;
        w_idxNext       = r_idx;
        w_seqNext       = r_seq;
        w_frameSeqNext  = r_frameSeq;
        w_leftNext      = r_left;
        w_rightNext     = r_right;
        w_dataNext      = r_data;
        w_dataRdyNext   = 1'b0;
        w_busyNext      = r_busy;
        w_frameDoneNext = 1'b0;
        w_overrunNext   = r_overrun | (bus.frame_start & (r_state != IDLE));

        case (r_state)
            IDLE: begin
                if (bus.frame_start) begin
                    w_leftNext     = bus.cnt_left;
                    w_rightNext    = bus.cnt_right;
                    w_frameSeqNext = r_seq;
                    w_idxNext      = 3'd0;
                    w_busyNext     = 1'b1;
                    w_stateNext    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.transm_rdy) begin
                    w_dataNext    = w_byte;
                    w_dataRdyNext = 1'b1;
                    w_stateNext   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!bus.transm_rdy) begin
                    w_stateNext = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.transm_rdy) begin
                    w_frameDoneNext = (r_idx == 3'd7);
                    w_stateNext     = NEXT;
                end
            end
            NEXT: begin
                if (r_idx == 3'd7) begin
                    w_busyNext  = 1'b0;
                    w_seqNext   = r_seq + 8'd1;
                    w_stateNext = IDLE;
                end else begin
                    w_idxNext   = r_idx + 3'd1;
                    w_stateNext = ISSUE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 3'd0;
            r_seq       <= 8'h00;
            r_frameSeq  <= 8'h00;
            r_left      <= 16'h0000;
            r_right     <= 16'h0000;
            r_data      <= 8'h00;
            r_dataRdy   <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_idx       <= w_idxNext;
            r_seq       <= w_seqNext;
            r_frameSeq  <= w_frameSeqNext;
            r_left      <= w_leftNext;
            r_right     <= w_rightNext;
            r_data      <= w_dataNext;
            r_dataRdy   <= w_dataRdyNext;
            r_busy      <= w_busyNext;
            r_frameDone <= w_frameDoneNext;
            r_overrun   <= w_overrunNext;
        end
    end

    assign bus.data       = r_data;
    assign bus.data_rdy   = r_dataRdy;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frameDone;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_odom_frame_tx.sv
// Self-checking bench for odom_frame_tx: a behavioural serializer plus a
// byte-level frame model derived from the frame layout and checksum rule.
`timescale 1ns/1ps
module tb_odom_frame_tx;

    logic clk;
    logic rst_n;

    odom_frame_tx_if bus ();

    odom_frame_tx #(
        .SYNC0 (8'hAA),
        .SYNC1 (8'h55)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         vectors   = 0;
    int         errors    = 0;
    logic [7:0] rxQ[$];
    int         doneCnt   = 0;
    int         protoViol = 0;
    bit         holdLow   = 1'b0;
    int         busyCnt   = 0;
    bit         pend      = 1'b0;
    bit         sawLow    = 1'b0;
    int         expSeq    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer: drops ready after taking a byte, raises it again 10 cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            busyCnt        = 0;
            pend           = 1'b0;
            sawLow         = 1'b0;
            bus.transm_rdy = !holdLow;
        end else begin
            if (bus.data_rdy === 1'b1) begin
                rxQ.push_back(bus.data);
                if (pend) protoViol++;
                pend    = 1'b1;
                sawLow  = 1'b0;
                busyCnt = 10;
            end else if (busyCnt > 0) begin
                busyCnt--;
            end
            if (bus.frame_done === 1'b1) doneCnt++;
            bus.transm_rdy = (busyCnt == 0) && !holdLow;
            if (pend && !bus.transm_rdy) sawLow = 1'b1;
            else if (pend && sawLow && bus.transm_rdy) pend = 1'b0;
        end
    end

    // Reference frame: layout and mod-256 checksum of seq plus the four count bytes.
    function automatic logic [7:0] modelByte(input int k, input int s, input int l, input int r);
        int sum;
        sum = (s % 256) + (l / 256) + (l % 256) + (r / 256) + (r % 256);
        case (k)
            0: return 8'hAA;
            1: return 8'h55;
            2: return 8'(s % 256);
            3: return 8'(l / 256);
            4: return 8'(l % 256);
            5: return 8'(r / 256);
            6: return 8'(r % 256);
            default: return 8'(sum % 256);
        endcase
    endfunction

    task automatic doReset();
        @(posedge clk); #1;
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxQ.delete();
        expSeq = 0;
        rst_n  = 1'b1;
    endtask

    task automatic driveStart(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk); #1;
        bus.frame_start = 1'b1;
        bus.cnt_left    = l;
        bus.cnt_right   = r;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    // Scrambles the count inputs while waiting, so a frame that does not hold its snapshot shows up.
    task automatic waitDone(input int budget, output bit timedOut);
        int startCnt = doneCnt;
        int n = 0;
        while (doneCnt == startCnt && n < budget) begin
            @(posedge clk); #1;
            n++;
            bus.cnt_left  = 16'($urandom);
            bus.cnt_right = 16'($urandom);
        end
        timedOut = (doneCnt == startCnt);
    endtask

    task automatic waitBytes(input int nBytes, input int budget, output bit timedOut);
        int n = 0;
        while (rxQ.size() < nBytes && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        timedOut = (rxQ.size() < nBytes);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.data); end
        vectors++; if (bus.data_rdy !== 1'b0) begin errors++; $display("FAIL reset_data_rdy got %b want 0", bus.data_rdy); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single_frame();
        logic [15:0] l = 16'h1234;
        logic [15:0] r = 16'hABCD;
        int  d0 = doneCnt;
        bit  to;
        rxQ.delete();
        driveStart(l, r);
        vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
        vectors++; if (bus.data_rdy !== 1'b0) begin errors++; $display("FAIL single_early_rdy got %b want 0", bus.data_rdy); end
        @(posedge clk); #1;
        vectors++; if (bus.data_rdy !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", bus.data_rdy); end
        vectors++; if (bus.data !== 8'hAA) begin errors++; $display("FAIL single_first_byte got %h want aa", bus.data); end
        waitDone(400, to);
        vectors++; if (to) begin errors++; $display("FAIL single_timeout got no frame_done want frame_done"); end
        vectors++; if (rxQ.size() != 8) begin errors++; $display("FAIL single_len got %0d want 8", rxQ.size()); end
        for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
            vectors++;
            if (rxQ[i] !== modelByte(i, expSeq, l, r)) begin
                errors++; $display("FAIL single_byte%0d got %h want %h", i, rxQ[i], modelByte(i, expSeq, l, r));
            end
        end
        expSeq = (expSeq + 1) % 256;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (doneCnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", doneCnt - d0); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        bit to;
        doReset();
        for (int f = 0; f < 3; f++) begin
            logic [15:0] l = 16'($urandom);
            logic [15:0] r = 16'($urandom);
            rxQ.delete();
            driveStart(l, r);
            waitDone(400, to);
            vectors++; if (to || rxQ.size() != 8) begin errors++; $display("FAIL b2b%0d_len got %0d want 8", f, rxQ.size()); end
            for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
                vectors++;
                if (rxQ[i] !== modelByte(i, expSeq, l, r)) begin
                    errors++; $display("FAIL b2b%0d_byte%0d got %h want %h", f, i, rxQ[i], modelByte(i, expSeq, l, r));
                end
            end
            expSeq = (expSeq + 1) % 256;
        end
        vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
        vectors++; if (protoViol != 0) begin errors++; $display("FAIL b2b_handshake got %0d want 0", protoViol); end
    endtask

    task automatic test_overrun();
        logic [15:0] l = 16'($urandom);
        logic [15:0] r = 16'($urandom);
        bit to;
        int d0;
        doReset();
        d0 = doneCnt;
        driveStart(l, r);
        waitBytes(4, 200, to);
        vectors++; if (to) begin errors++; $display("FAIL ovr_wait got %0d bytes want 4", rxQ.size()); end
        driveStart(~l, ~r);
        waitDone(400, to);
        vectors++; if (to || rxQ.size() != 8) begin errors++; $display("FAIL ovr_len got %0d want 8", rxQ.size()); end
        for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
            vectors++;
            if (rxQ[i] !== modelByte(i, expSeq, l, r)) begin
                errors++; $display("FAIL ovr_byte%0d got %h want %h", i, rxQ[i], modelByte(i, expSeq, l, r));
            end
        end
        expSeq = (expSeq + 1) % 256;
        vectors++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
        repeat (60) @(posedge clk);
        #1;
        vectors++; if (rxQ.size() != 8) begin errors++; $display("FAIL ovr_no_second got %0d bytes want 8", rxQ.size()); end
        vectors++; if (doneCnt - d0 != 1) begin errors++; $display("FAIL ovr_done_count got %0d want 1", doneCnt - d0); end
        vectors++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
        doReset();
        vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", bus.overrun); end
    endtask

    task automatic test_done_collision();
        logic [15:0] l = 16'($urandom);
        logic [15:0] r = 16'($urandom);
        int n = 0;
        doReset();
        driveStart(l, r);
        while (bus.frame_done !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL coll_done got %b want 1", bus.frame_done); end
        vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL coll_pre_overrun got %b want 0", bus.overrun); end
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        vectors++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL coll_overrun got %b want 1", bus.overrun); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coll_busy got %b want 0", bus.busy); end
        repeat (40) @(posedge clk);
        #1;
        vectors++; if (rxQ.size() != 8) begin errors++; $display("FAIL coll_len got %0d want 8", rxQ.size()); end
        for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
            vectors++;
            if (rxQ[i] !== modelByte(i, expSeq, l, r)) begin
                errors++; $display("FAIL coll_byte%0d got %h want %h", i, rxQ[i], modelByte(i, expSeq, l, r));
            end
        end
        expSeq = (expSeq + 1) % 256;
    endtask

    task automatic test_stall();
        logic [15:0] l = 16'($urandom);
        logic [15:0] r = 16'($urandom);
        bit sawRdy = 1'b0;
        bit to;
        doReset();
        holdLow = 1'b1;
        @(negedge clk);
        driveStart(l, r);
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.data_rdy === 1'b1) sawRdy = 1'b1;
        end
        vectors++; if (sawRdy || rxQ.size() != 0) begin errors++; $display("FAIL stall_rdy got %0d bytes want 0", rxQ.size()); end
        vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", bus.busy); end
        holdLow = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.data_rdy !== 1'b1 || bus.data !== 8'hAA) begin
            errors++; $display("FAIL stall_release got rdy=%b data=%h want rdy=1 data=aa", bus.data_rdy, bus.data);
        end
        waitDone(400, to);
        vectors++; if (to || rxQ.size() != 8) begin errors++; $display("FAIL stall_len got %0d want 8", rxQ.size()); end
        for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
            vectors++;
            if (rxQ[i] !== modelByte(i, expSeq, l, r)) begin
                errors++; $display("FAIL stall_byte%0d got %h want %h", i, rxQ[i], modelByte(i, expSeq, l, r));
            end
        end
        expSeq = (expSeq + 1) % 256;
    endtask

    task automatic test_reset_mid();
        logic [15:0] l = {8'($urandom), 8'h5A};
        logic [15:0] r = 16'($urandom);
        bit to;
        doReset();
        driveStart(l, r);
        waitBytes(5, 200, to);
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b1 || bus.data !== l[7:0]) begin
            errors++; $display("FAIL rmid_pre got busy=%b data=%h want busy=1 data=%h", bus.busy, bus.data, l[7:0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", bus.data); end
        vectors++; if (bus.busy !== 1'b0 || bus.data_rdy !== 1'b0 || bus.frame_done !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL rmid_flags got busy=%b rdy=%b done=%b ovr=%b want 0000", bus.busy, bus.data_rdy, bus.frame_done, bus.overrun);
        end
        repeat (2) @(posedge clk);
        #1;
        rxQ.delete();
        expSeq = 0;
        rst_n  = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        vectors++; if (rxQ.size() != 0) begin errors++; $display("FAIL rmid_aborted got %0d bytes want 0", rxQ.size()); end
        l = 16'($urandom);
        r = 16'($urandom);
        driveStart(l, r);
        waitDone(400, to);
        vectors++; if (to || rxQ.size() != 8) begin errors++; $display("FAIL rmid_len got %0d want 8", rxQ.size()); end
        for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
            vectors++;
            if (rxQ[i] !== modelByte(i, expSeq, l, r)) begin
                errors++; $display("FAIL rmid_byte%0d got %h want %h", i, rxQ[i], modelByte(i, expSeq, l, r));
            end
        end
        expSeq = (expSeq + 1) % 256;
    endtask

    task automatic test_seq_wrap();
        bit to;
        int bad;
        doReset();
        for (int f = 0; f < 257; f++) begin
            rxQ.delete();
            driveStart(16'hFFFF, 16'hFFFF);
            waitDone(400, to);
            bad = (to || rxQ.size() != 8) ? 1 : 0;
            for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
                if (rxQ[i] !== modelByte(i, expSeq, 16'hFFFF, 16'hFFFF)) bad++;
            end
            vectors++;
            if (bad != 0) begin errors++; $display("FAIL wrap_frame%0d got %0d bad bytes want 0", f, bad); end
            if (f == 255) begin
                vectors++; if (rxQ.size() < 8 || rxQ[2] !== 8'hFF) begin errors++; $display("FAIL wrap_seq_ff got %h want ff", (rxQ.size() > 2) ? rxQ[2] : 8'hxx); end
                vectors++; if (rxQ.size() < 8 || rxQ[7] !== 8'hFB) begin errors++; $display("FAIL wrap_chk got %h want fb", (rxQ.size() > 7) ? rxQ[7] : 8'hxx); end
            end
            if (f == 256) begin
                vectors++; if (rxQ.size() < 8 || rxQ[2] !== 8'h00) begin errors++; $display("FAIL wrap_seq_00 got %h want 00", (rxQ.size() > 2) ? rxQ[2] : 8'hxx); end
            end
            expSeq = (expSeq + 1) % 256;
        end
        vectors++; if (protoViol != 0) begin errors++; $display("FAIL handshake_total got %0d want 0", protoViol); end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.cnt_left    = 16'h0000;
        bus.cnt_right   = 16'h0000;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_done_collision();
        test_stall();
        test_reset_mid();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
